// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides and a 1-cycle result latency.
// Define ALU_MUL_EN to build the multi-cycle shift-add multiply for code 1000.
module alu_exec_unit #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alucontrol,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         zero
);

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_t;
`else
  typedef enum logic {IDLE, HOLD} state_t;
`endif

  state_t       state, state_n;
  logic [N-1:0] result_n;
  logic         zero_n;
  logic         accept;
  logic [N-1:0] op_res;
  logic         op_zero;

  always_comb begin
    op_res = '0;
    case (alucontrol)
      4'b0000:          op_res = a & b;
      4'b0001:          op_res = a | b;
      4'b0010:          op_res = a + b;
      4'b0110:          op_res = a - b;
      4'b0111, 4'b1111: op_res = b;
      default:          op_res = '0;
    endcase
    // CBNZ reports its take-condition rather than a zero result
    op_zero = (alucontrol == 4'b1111) ? (b != '0) : (op_res == '0);
  end

`ifdef ALU_MUL_EN
  localparam int unsigned CW = $clog2(N);

  logic [N-1:0]  a_sh, b_sh, acc;
  logic [N-1:0]  a_sh_n, b_sh_n, acc_n, acc_sum;
  logic [CW-1:0] cnt, cnt_n;

  assign in_ready = reset & ((state == IDLE) | ((state == HOLD) & out_ready));
`else
  assign in_ready = reset & ((state == IDLE) | out_ready);
`endif

  assign accept    = in_valid & in_ready;
  assign out_valid = (state == HOLD);

  always_comb begin
    state_n  = state;
    result_n = result;
    zero_n   = zero;
`ifdef ALU_MUL_EN
    a_sh_n   = a_sh;
    b_sh_n   = b_sh;
    acc_n    = acc;
    cnt_n    = cnt;
    acc_sum  = b_sh[0] ? (acc + a_sh) : acc;
`endif

    case (state)
      HOLD: if (out_ready) state_n = IDLE;
`ifdef ALU_MUL_EN
      MUL: begin
        acc_n  = acc_sum;
        a_sh_n = {a_sh[N-2:0], 1'b0};
        b_sh_n = {1'b0, b_sh[N-1:1]};
        cnt_n  = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_n  = HOLD;
          result_n = acc_sum;
          zero_n   = (acc_sum == '0);
        end
      end
`endif
      default: ;
    endcase

    // accept only fires in IDLE or in HOLD while draining, so it overrides the drain
    if (accept) begin
`ifdef ALU_MUL_EN
      if (alucontrol == 4'b1000) begin
        state_n = MUL;
        a_sh_n  = a;
        b_sh_n  = b;
        acc_n   = '0;
        cnt_n   = '0;
      end else begin
`endif
        state_n  = HOLD;
        result_n = op_res;
        zero_n   = op_zero;
`ifdef ALU_MUL_EN
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      result <= '0;
      zero   <= 1'b0;
`ifdef ALU_MUL_EN
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
`endif
    end else begin
      state  <= state_n;
      result <= result_n;
      zero   <= zero_n;
`ifdef ALU_MUL_EN
      a_sh   <= a_sh_n;
      b_sh   <= b_sh_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized self-checking bench for alu_exec_unit against an arithmetic reference model.
// Follows ALU_MUL_EN the same way the design does.
module tb_alu_exec_unit;
  localparam int unsigned N = 64;
`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alucontrol = '0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] result;
  logic         zero;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  alu_exec_unit #(.N(N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] c, input logic [N-1:0] x, input logic [N-1:0] y,
                                output logic [N-1:0] r, output logic z);
    case (c)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x + y;
      4'd6:  r = x - y;
      4'd7:  r = y;
      4'd15: r = y;
      4'd8:  r = MUL_ON ? x * y : '0;
      default: r = '0;
    endcase
    z = (c == 4'd15) ? (y != '0) : (r == '0);
  endfunction

  function automatic logic [N-1:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return N'($urandom_range(0, 3));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Issues one op, waits for its result, checks latency, busy in_ready, result and zero.
  // Leaves the unit in HOLD with out_ready low, positioned at a falling edge.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [N-1:0] x, input logic [N-1:0] y);
    logic [N-1:0] er;
    logic         ez;
    int unsigned  lat, w, el;
    bit           busy_ok;
    model(c, x, y, er, ez);
    el = (MUL_ON && c == 4'd8) ? N + 1 : 1;
    alucontrol = c; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    w = 0;
    #1;
    while (!in_ready && w < 200) begin
      @(negedge clk); #1; w++;
    end
    check({tag, "/in_ready"}, N'(in_ready), N'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    alucontrol = 4'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    lat = 1; busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    out_ready = 1'b0;
    check({tag, "/latency"}, N'(lat), N'(el));
    check({tag, "/busy"}, N'(busy_ok), N'(1));
    check({tag, "/out_valid"}, N'(out_valid), N'(1));
    check({tag, "/result"}, result, er);
    check({tag, "/zero"}, N'(zero), N'(ez));
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] held;
    logic [3:0]   c;
    int unsigned  muls;

    #12;
    check("rst/in_ready", N'(in_ready), N'(0));
    check("rst/out_valid", N'(out_valid), N'(0));
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle/in_ready", N'(in_ready), N'(1));
    check("idle/out_valid", N'(out_valid), N'(0));
    check("idle/result", result, '0);
    @(negedge clk);

    run_op("add5_7", 4'd2, N'(5), N'(7));
    run_op("sub_eq", 4'd6, N'(9), N'(9));
    run_op("sub_wrap", 4'd6, N'(0), N'(1));
    run_op("cbnz", 4'd15, N'(0), N'(3));
    run_op("cbz0", 4'd7, N'(123), N'(0));
    run_op("unk3", 4'd3, N'(77), N'(88));
    run_op("code8", 4'd8, N'(6), N'(7));
    run_op("code8_wrap", 4'd8, {1'b1, {(N-1){1'b0}}}, N'(2));

    // back-to-back with out_ready held high
    out_ready = 1'b1; in_valid = 1'b1;
    alucontrol = 4'd0; a = N'(8'hF0); b = N'(8'h3C);
    @(negedge clk);
    check("b2b0/result", result, N'(8'h30));
    check("b2b0/in_ready", N'(in_ready), N'(1));
    alucontrol = 4'd1; a = N'(8'hF0); b = N'(8'h0F);
    @(negedge clk);
    check("b2b1/result", result, N'(8'hFF));
    alucontrol = 4'd2; a = N'(1); b = N'(1);
    @(negedge clk);
    check("b2b2/result", result, N'(2));
    check("b2b2/out_valid", N'(out_valid), N'(1));
    out_ready = 1'b0;
    held = result;
    for (int unsigned i = 0; i < 3; i++) begin
      alucontrol = 4'd2; a = {$urandom, $urandom}; b = N'(i + 1);
      #1;
      check("hold/in_ready", N'(in_ready), N'(0));
      @(negedge clk);
      check("hold/result", result, held);
      check("hold/out_valid", N'(out_valid), N'(1));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("drain/out_valid", N'(out_valid), N'(0));
    out_ready = 1'b0;

    muls = 0;
    for (int unsigned i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 0) c = 4'($urandom_range(0, 15));
      else begin
        case ($urandom_range(0, 5))
          0: c = 4'd0; 1: c = 4'd1; 2: c = 4'd2;
          3: c = 4'd6; 4: c = 4'd7; default: c = 4'd15;
        endcase
      end
      if (c == 4'd8 && MUL_ON) begin
        if (muls >= 20) c = 4'd2;
        else muls++;
      end
      a = rand_val();
      b = ($urandom_range(0, 4) == 0) ? a : rand_val();
      run_op($sformatf("rnd%0d_c%0d", i, c), c, a, b);
    end

    // reset while a result is held
    reset = 1'b0;
    #1;
    check("rsthold/out_valid", N'(out_valid), N'(0));
    check("rsthold/result", result, '0);
    check("rsthold/zero", N'(zero), N'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    if (MUL_ON) begin
      alucontrol = 4'd8; a = N'(6); b = N'(7); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rstmul/out_valid", N'(out_valid), N'(0));
      check("rstmul/result", result, '0);
      check("rstmul/in_ready", N'(in_ready), N'(0));
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b0;
      repeat (N + 4) begin
        @(negedge clk);
        if (out_valid) break;
      end
      check("rstmul/no_late_valid", N'(out_valid), N'(0));
    end
    run_op("post_rst_add", 4'd2, N'(1), N'(2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
